exe_stage_mdu: RTL and testbench

- Parametrised next-generation execute stage of the 5-stage in-order pipeline, between decode (ds) and memory (ms).
- Adds to the single-cycle EX:
  - a multi-cycle iterative divider that stalls the stage;
  - sub-word stores with byte strobes and misalignment detection;
  - a flush input;
  - a forwarding bus that reports when the result is not yet available.
- The pipeline register holds its contents while the stage is stalled.
- Reuses the existing `alu` module for all non-divide ops.

---
 rtl/exe_pkg.sv | 62 ++++++
 rtl/alu.sv | 41 ++++
 rtl/exe_stage_mdu_div_iter.sv | 94 +++++++++
 rtl/exe_stage_mdu.sv | 131 +++++++++++++
 tb/tb_exe_stage_mdu.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/exe_pkg.sv
// Shared encodings, bus layout helpers and FSM states for the execute stage.
package exe_pkg;

    localparam logic [2:0] DIV_NONE = 3'd0;
    localparam logic [2:0] DIV_W    = 3'd1;
    localparam logic [2:0] MOD_W    = 3'd2;
    localparam logic [2:0] DIV_WU   = 3'd3;
    localparam logic [2:0] MOD_WU   = 3'd4;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;
    localparam logic [1:0] MEM_D = 2'd3;

    // ds_to_es_bus layout, LSB upward: mem_size, div_op, res_from_mem,
    // src2_is_imm, src1_is_pc, alu_op, mem_we, gr_we, dest, imm, rkd, rj, pc
    localparam int OFF_MEM_SIZE     = 0;
    localparam int OFF_DIV_OP       = 2;
    localparam int OFF_RES_FROM_MEM = 5;
    localparam int OFF_SRC2_IS_IMM  = 6;
    localparam int OFF_SRC1_IS_PC   = 7;
    localparam int OFF_ALU_OP       = 8;

    function automatic int off_mem_we(input int alu_op_w);
        return 8 + alu_op_w;
    endfunction
    function automatic int off_gr_we(input int alu_op_w);
        return 9 + alu_op_w;
    endfunction
    function automatic int off_dest(input int alu_op_w);
        return 10 + alu_op_w;
    endfunction
    function automatic int off_imm(input int alu_op_w);
        return 15 + alu_op_w;
    endfunction
    function automatic int off_rkd(input int xlen, input int alu_op_w);
        return 15 + alu_op_w + xlen;
    endfunction
    function automatic int off_rj(input int xlen, input int alu_op_w);
        return 15 + alu_op_w + 2 * xlen;
    endfunction
    function automatic int off_pc(input int xlen, input int alu_op_w);
        return 15 + alu_op_w + 3 * xlen;
    endfunction

    function automatic int ds_es_w(input int xlen, input int alu_op_w);
        return 4 * xlen + 5 + 1 + 1 + alu_op_w + 1 + 1 + 1 + 3 + 2;
    endfunction
    function automatic int es_ms_w(input int xlen);
        return xlen + xlen + 5 + 1 + 1 + 1;
    endfunction
    function automatic int es_ds_w(input int xlen);
        return 1 + 5 + 1 + xlen;
    endfunction

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle ALU; alu_op is one-hot, one bit per operation.
module alu #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 15
) (
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [XLEN-1:0]     alu_src1,
    input  logic [XLEN-1:0]     alu_src2,
    output logic [XLEN-1:0]     alu_result
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] sum, diff, slt_r, sltu_r, sll_r, srl_r, sra_r;
    logic [SHW-1:0]  shamt;

    always_comb begin
        shamt  = alu_src2[SHW-1:0];
        sum    = alu_src1 + alu_src2;
        diff   = alu_src1 - alu_src2;
        slt_r  = {{(XLEN-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
        sltu_r = {{(XLEN-1){1'b0}}, (alu_src1 < alu_src2)};
        sll_r  = alu_src1 << shamt;
        srl_r  = alu_src1 >> shamt;
        sra_r  = $signed(alu_src1) >>> shamt;
        alu_result = ({XLEN{alu_op[0]}}  & sum)
                   | ({XLEN{alu_op[1]}}  & diff)
                   | ({XLEN{alu_op[2]}}  & slt_r)
                   | ({XLEN{alu_op[3]}}  & sltu_r)
                   | ({XLEN{alu_op[4]}}  & (alu_src1 & alu_src2))
                   | ({XLEN{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                   | ({XLEN{alu_op[6]}}  & (alu_src1 | alu_src2))
                   | ({XLEN{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                   | ({XLEN{alu_op[8]}}  & sll_r)
                   | ({XLEN{alu_op[9]}}  & srl_r)
                   | ({XLEN{alu_op[10]}} & sra_r)
                   | ({XLEN{alu_op[11]}} & alu_src2)
                   | ({XLEN{alu_op[12]}} & (alu_src1 & ~alu_src2))
                   | ({XLEN{alu_op[13]}} & (alu_src1 | ~alu_src2))
                   | ({XLEN{alu_op[14]}} & alu_src1);
    end
endmodule

// File: rtl/exe_stage_mdu_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, sign fix-up in DONE.
module div_iter
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            signed_op,
    input  logic            want_rem,
    input  logic            ack,
    input  logic            kill,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);

    div_state_t      state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] quo, rem_r, dvs, dvd_raw;
    logic            neg_q, neg_r, div0, want_rem_r;
    logic [XLEN-1:0] a_abs, b_abs, q_fix, r_fix;
    logic [XLEN:0]   trial;

    always_comb begin
        a_abs = (signed_op && a[XLEN-1]) ? -a : a;
        b_abs = (signed_op && b[XLEN-1]) ? -b : b;
        trial = {rem_r, quo[XLEN-1]} - {1'b0, dvs};
    end

    always_comb begin
        state_nx = state;
        if (kill) begin
            state_nx = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (start)          state_nx = DIV_BUSY;
                DIV_BUSY: if (cnt == '0)      state_nx = DIV_DONE;
                DIV_DONE: if (ack)            state_nx = DIV_IDLE;
                default:                      state_nx = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= DIV_IDLE;
            cnt        <= '0;
            quo        <= '0;
            rem_r      <= '0;
            dvs        <= '0;
            dvd_raw    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div0       <= 1'b0;
            want_rem_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == DIV_IDLE && start && !kill) begin
                cnt        <= CNT_W'(XLEN - 1);
                quo        <= a_abs;
                rem_r      <= '0;
                dvs        <= b_abs;
                dvd_raw    <= a;
                div0       <= (b == '0);
                neg_q      <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
                neg_r      <= signed_op && a[XLEN-1];
                want_rem_r <= want_rem;
            end else if (state == DIV_BUSY) begin
                cnt <= cnt - CNT_W'(1);
                if (!trial[XLEN]) begin
                    rem_r <= trial[XLEN-1:0];
                    quo   <= {quo[XLEN-2:0], 1'b1};
                end else begin
                    rem_r <= {rem_r[XLEN-2:0], quo[XLEN-1]};
                    quo   <= {quo[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    // Divide-by-zero bypasses sign correction so the quotient stays all-ones.
    always_comb begin
        q_fix  = div0 ? '1 : (neg_q ? -quo : quo);
        r_fix  = div0 ? dvd_raw : (neg_r ? -rem_r : rem_r);
        result = want_rem_r ? r_fix : q_fix;
        busy   = (state == DIV_BUSY);
        done   = (state == DIV_DONE);
    end
endmodule

// File: rtl/exe_stage_mdu.sv
// Execute stage with iterative divider, sub-word stores, flush and forwarding.
module exe_stage_mdu
    import exe_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int ALU_OP_W = 15,
    localparam int DS_ES_W  = ds_es_w(XLEN, ALU_OP_W),
    localparam int ES_MS_W  = es_ms_w(XLEN),
    localparam int ES_DS_W  = es_ds_w(XLEN)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ds_to_es_valid,
    output logic                es_allow_in,
    input  logic [DS_ES_W-1:0]  ds_to_es_bus,
    input  logic                ms_allow_in,
    output logic                es_to_ms_valid,
    output logic [ES_MS_W-1:0]  es_to_ms_bus,
    output logic [ES_DS_W-1:0]  es_to_ds_bus,
    input  logic                flush,
    output logic                data_sram_en,
    output logic [XLEN/8-1:0]   data_sram_wen,
    output logic [XLEN-1:0]     data_sram_addr,
    output logic [XLEN-1:0]     data_sram_wdata
);
    localparam int OFF_W = $clog2(XLEN / 8);

    logic               es_valid, es_ready_go;
    logic [DS_ES_W-1:0] ds_es_reg;

    logic [XLEN-1:0]     pc, rj, rkd, imm, src1, src2, alu_result, div_result, es_result;
    logic [4:0]          dest;
    logic                gr_we, mem_we, src1_is_pc, src2_is_imm, res_from_mem;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          div_op;
    logic [1:0]          mem_size;
    logic                is_div, div_signed, div_rem, div_busy, div_done, div_start;
    logic [3:0]          nbytes;
    logic [OFF_W-1:0]    addr_off;
    logic                mem_access, ale;
    logic [XLEN/8-1:0]   lane_mask;

    always_comb begin
        mem_size     = ds_es_reg[OFF_MEM_SIZE +: 2];
        div_op       = ds_es_reg[OFF_DIV_OP +: 3];
        res_from_mem = ds_es_reg[OFF_RES_FROM_MEM];
        src2_is_imm  = ds_es_reg[OFF_SRC2_IS_IMM];
        src1_is_pc   = ds_es_reg[OFF_SRC1_IS_PC];
        alu_op       = ds_es_reg[OFF_ALU_OP +: ALU_OP_W];
        mem_we       = ds_es_reg[off_mem_we(ALU_OP_W)];
        gr_we        = ds_es_reg[off_gr_we(ALU_OP_W)];
        dest         = ds_es_reg[off_dest(ALU_OP_W) +: 5];
        imm          = ds_es_reg[off_imm(ALU_OP_W) +: XLEN];
        rkd          = ds_es_reg[off_rkd(XLEN, ALU_OP_W) +: XLEN];
        rj           = ds_es_reg[off_rj(XLEN, ALU_OP_W) +: XLEN];
        pc           = ds_es_reg[off_pc(XLEN, ALU_OP_W) +: XLEN];
        src1         = src1_is_pc ? pc : rj;
        src2         = src2_is_imm ? imm : rkd;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid  <= 1'b0;
            ds_es_reg <= '0;
        end else begin
            if (flush)            es_valid <= 1'b0;
            else if (es_allow_in) es_valid <= ds_to_es_valid;
            if (ds_to_es_valid && es_allow_in) ds_es_reg <= ds_to_es_bus;
        end
    end

    alu #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) u_alu (
        .alu_op     (alu_op),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_result)
    );

    always_comb begin
        is_div     = (div_op >= DIV_W) && (div_op <= MOD_WU);
        div_signed = (div_op == DIV_W) || (div_op == MOD_W);
        div_rem    = (div_op == MOD_W) || (div_op == MOD_WU);
        div_start  = es_valid && is_div && !div_busy && !div_done && !flush;
    end

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .signed_op (div_signed),
        .want_rem  (div_rem),
        .ack       (es_allow_in),
        .kill      (flush),
        .a         (src1),
        .b         (src2),
        .busy      (div_busy),
        .done      (div_done),
        .result    (div_result)
    );

    always_comb begin
        es_result      = is_div ? div_result : alu_result;
        es_ready_go    = is_div ? div_done : 1'b1;
        es_allow_in    = !es_valid || (es_ready_go && ms_allow_in);
        es_to_ms_valid = es_valid && es_ready_go && !flush;
    end

    // Oversized accesses (e.g. a doubleword on a 32-bit datapath) are flagged like misalignment.
    always_comb begin
        nbytes     = 4'd1 << mem_size;
        addr_off   = alu_result[OFF_W-1:0];
        mem_access = mem_we || res_from_mem;
        ale        = mem_access &&
                     ((((nbytes - 4'd1) & 4'(addr_off)) != 4'd0) || (int'(nbytes) > XLEN / 8));
        for (int unsigned i = 0; i < XLEN / 8; i++) lane_mask[i] = (i < 32'(nbytes));
        data_sram_en    = es_valid && mem_access && !ale && !flush;
        data_sram_wen   = (data_sram_en && mem_we && ms_allow_in) ? (lane_mask << addr_off) : '0;
        data_sram_addr  = alu_result;
        case (mem_size)
            MEM_B:   data_sram_wdata = {(XLEN/8){rkd[7:0]}};
            MEM_H:   data_sram_wdata = {(XLEN/16){rkd[15:0]}};
            MEM_W:   data_sram_wdata = {(XLEN/32){rkd[31:0]}};
            default: data_sram_wdata = rkd;
        endcase
    end

    always_comb begin
        es_to_ms_bus = {pc, es_result, dest, gr_we, res_from_mem, ale};
        es_to_ds_bus = {es_valid && gr_we, dest, res_from_mem || (is_div && !div_done), es_result};
    end
endmodule

// File: tb/tb_exe_stage_mdu.sv
// Directed bench for exe_stage_mdu at XLEN=32: ALU, divides, stores, stall, flush, reset.
module tb_exe_stage_mdu;
    localparam int XLEN    = 32;
    localparam int AW      = 15;
    localparam int DS_ES_W = 4 * XLEN + 5 + 1 + 1 + AW + 1 + 1 + 1 + 3 + 2;
    localparam int ES_MS_W = XLEN + XLEN + 5 + 1 + 1 + 1;
    localparam int ES_DS_W = 1 + 5 + 1 + XLEN;
    localparam logic [AW-1:0] OP_ADD  = 15'h0001;
    localparam logic [AW-1:0] OP_NONE = 15'h0000;

    logic               clk, resetn, ds_to_es_valid, es_allow_in, ms_allow_in;
    logic               es_to_ms_valid, flush, data_sram_en;
    logic [DS_ES_W-1:0] ds_to_es_bus;
    logic [ES_MS_W-1:0] es_to_ms_bus;
    logic [ES_DS_W-1:0] es_to_ds_bus;
    logic [3:0]         data_sram_wen;
    logic [31:0]        data_sram_addr, data_sram_wdata;

    int passed = 0;
    int total  = 0;

    exe_stage_mdu #(.XLEN(XLEN), .ALU_OP_W(AW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_to_es_valid  (ds_to_es_valid),
        .es_allow_in     (es_allow_in),
        .ds_to_es_bus    (ds_to_es_bus),
        .ms_allow_in     (ms_allow_in),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_to_ds_bus    (es_to_ds_bus),
        .flush           (flush),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [DS_ES_W-1:0] mk(
        input logic [31:0] pc, rj, rkd, imm, input logic [4:0] dest,
        input logic gr_we, mem_we, input logic [AW-1:0] op,
        input logic s1pc, s2imm, rfm, input logic [2:0] dop, input logic [1:0] msz);
        return {pc, rj, rkd, imm, dest, gr_we, mem_we, op, s1pc, s2imm, rfm, dop, msz};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present one instruction for a single accepting edge; returns 2ns after the edge.
    task automatic issue(input logic [DS_ES_W-1:0] bus);
        ds_to_es_bus   = bus;
        ds_to_es_valid = 1'b1;
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        #1;
    endtask

    task automatic run_div(input string tag, input logic [DS_ES_W-1:0] bus, input logic [31:0] exp);
        int n;
        issue(bus);
        n = 0;
        while (!es_to_ms_valid && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        check({tag, "_latency"}, n, 33);
        check({tag, "_result"}, es_to_ms_bus[39:8], exp);
    endtask

    initial begin
        resetn = 1'b0; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
        ms_allow_in = 1'b1; flush = 1'b0;
        #3;
        check("rst_ms_valid", es_to_ms_valid, 0);
        check("rst_sram_en",  data_sram_en, 0);
        check("rst_wen",      data_sram_wen, 0);
        check("rst_fwd_we",   es_to_ds_bus[38], 0);
        check("rst_allow_in", es_allow_in, 1);
        #9 resetn = 1'b1;
        @(posedge clk); #1;

        issue(mk(32'h1c000000, 5, 7, 0, 5'd3, 1, 0, OP_ADD, 0, 0, 0, 3'd0, 2'd2));
        check("add_valid",     es_to_ms_valid, 1);
        check("add_result",    es_to_ms_bus[39:8], 12);
        check("add_pc",        es_to_ms_bus[71:40], 32'h1c000000);
        check("add_wen",       data_sram_wen, 0);
        check("add_fwd",       es_to_ds_bus, {1'b1, 5'd3, 1'b0, 32'd12});

        issue(mk(32'h1c000004, 32'hFFFFFFF9, 2, 0, 5'd4, 1, 0, OP_NONE, 0, 0, 0, 3'd1, 2'd2));
        for (int c = 0; c <= 32; c++) begin
            check("divw_wait_valid", es_to_ms_valid, 0);
            check("divw_wait_block", es_to_ds_bus[32], 1);
            @(posedge clk); #2;
        end
        check("divw_valid",  es_to_ms_valid, 1);
        check("divw_result", es_to_ms_bus[39:8], 32'hFFFFFFFD);
        check("divw_fwd",    es_to_ds_bus, {1'b1, 5'd4, 1'b0, 32'hFFFFFFFD});

        run_div("modwu_by0",  mk(0, 9, 0, 0, 5'd1, 1, 0, OP_NONE, 0, 0, 0, 3'd4, 2'd2), 32'd9);
        run_div("divw_ovf",   mk(0, 32'h80000000, 32'hFFFFFFFF, 0, 5'd1, 1, 0, OP_NONE, 0, 0, 0, 3'd1, 2'd2), 32'h80000000);
        run_div("divwu_by0",  mk(0, 5, 0, 0, 5'd1, 1, 0, OP_NONE, 0, 0, 0, 3'd3, 2'd2), 32'hFFFFFFFF);
        run_div("modw_neg",   mk(0, 32'hFFFFFFF9, 2, 0, 5'd1, 1, 0, OP_NONE, 0, 0, 0, 3'd2, 2'd2), 32'hFFFFFFFF);
        run_div("divw_negb",  mk(0, 100, 32'hFFFFFFF9, 0, 5'd1, 1, 0, OP_NONE, 0, 0, 0, 3'd1, 2'd2), 32'hFFFFFFF2);

        issue(mk(32'h1c000100, 32'h1000, 32'hAB, 3, 5'd0, 0, 1, OP_ADD, 0, 1, 0, 3'd0, 2'd0));
        check("stb_wen",   data_sram_wen, 4'b1000);
        check("stb_wdata", data_sram_wdata, 32'hABABABAB);
        check("stb_en",    data_sram_en, 1);
        check("stb_ale",   es_to_ms_bus[0], 0);
        issue(mk(32'h1c000104, 32'h1000, 32'hAB, 2, 5'd0, 0, 1, OP_ADD, 0, 1, 0, 3'd0, 2'd1));
        check("sth_wen",   data_sram_wen, 4'b1100);
        check("sth_wdata", data_sram_wdata, 32'h00AB00AB);
        issue(mk(32'h1c000108, 32'h1000, 32'hAB, 2, 5'd0, 0, 1, OP_ADD, 0, 1, 0, 3'd0, 2'd2));
        check("stw_mis_wen", data_sram_wen, 0);
        check("stw_mis_en",  data_sram_en, 0);
        check("stw_mis_ale", es_to_ms_bus[0], 1);
        issue(mk(32'h1c00010c, 32'h1000, 0, 4, 5'd6, 1, 0, OP_ADD, 0, 1, 1, 3'd0, 2'd2));
        check("ldw_en",    data_sram_en, 1);
        check("ldw_wen",   data_sram_wen, 0);
        check("ldw_block", es_to_ds_bus[32], 1);

        ds_to_es_bus   = mk(32'h1c000200, 32'h1000, 32'h12345678, 0, 5'd0, 0, 1, OP_ADD, 0, 1, 0, 3'd0, 2'd2);
        ds_to_es_valid = 1'b1;
        @(posedge clk); #1;
        ms_allow_in  = 1'b0;
        ds_to_es_bus = mk(32'h1c000300, 20, 22, 0, 5'd5, 1, 0, OP_ADD, 0, 0, 0, 3'd0, 2'd2);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_wen",      data_sram_wen, 0);
            check("stall_allow_in", es_allow_in, 0);
            check("stall_pc",       es_to_ms_bus[71:40], 32'h1c000200);
            check("stall_addr",     data_sram_addr, 32'h1000);
            @(posedge clk); #2;
        end
        ms_allow_in = 1'b1;
        #1;
        check("release_wen",   data_sram_wen, 4'b1111);
        check("release_wdata", data_sram_wdata, 32'h12345678);
        check("release_valid", es_to_ms_valid, 1);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        #1;
        check("after_wen",    data_sram_wen, 0);
        check("after_pc",     es_to_ms_bus[71:40], 32'h1c000300);
        check("after_result", es_to_ms_bus[39:8], 42);

        issue(mk(32'h1c000400, 100, 7, 0, 5'd7, 1, 0, OP_NONE, 0, 0, 0, 3'd3, 2'd2));
        repeat (10) begin @(posedge clk); #2; end
        check("flush_busy_block", es_to_ds_bus[32], 1);
        flush = 1'b1;
        #1;
        check("flush_ms_valid", es_to_ms_valid, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flushed_fwd_we",   es_to_ds_bus[38], 0);
        check("flushed_ms_valid", es_to_ms_valid, 0);
        check("flushed_allow_in", es_allow_in, 1);
        run_div("div_after_flush", mk(0, 100, 7, 0, 5'd7, 1, 0, OP_NONE, 0, 0, 0, 3'd3, 2'd2), 32'd14);

        issue(mk(32'h1c000500, 100, 7, 0, 5'd8, 1, 0, OP_NONE, 0, 0, 0, 3'd1, 2'd2));
        repeat (5) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("arst_ms_valid", es_to_ms_valid, 0);
        check("arst_sram_en",  data_sram_en, 0);
        check("arst_wen",      data_sram_wen, 0);
        check("arst_ds_bus",   es_to_ds_bus, 0);
        check("arst_ms_bus",   es_to_ms_bus, 0);
        #2 resetn = 1'b1;
        @(posedge clk); #1;
        issue(mk(32'h1c000600, 5, 7, 0, 5'd3, 1, 0, OP_ADD, 0, 0, 0, 3'd0, 2'd2));
        check("post_rst_valid",  es_to_ms_valid, 1);
        check("post_rst_result", es_to_ms_bus[39:8], 12);
        run_div("post_rst_div", mk(0, 100, 7, 0, 5'd9, 1, 0, OP_NONE, 0, 0, 0, 3'd1, 2'd2), 32'd14);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
